pipe_ex_stage: RTL
==================

Name: pipe_ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID/EX pipeline register outputs (control, RsE/RtE/RdE, RFD1/RFD2, SIMM).
- Applies hazard-unit forwarding, computes the ALU result (single-cycle ops plus an iterative shift-add multiply that stalls the front end), selects the destination register, and holds the EX/MEM pipeline register feeding the memory stage.

Parameters:
- WIDTH, 32, datapath width. Multiply takes WIDTH iteration cycles.
- RA_W, 5, register-address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- CLR_N  in  1  asynchronous, active-low reset
- RFWEE, DMWEE, MtoRFsel_E, RFDSelE, ALU_sel_E  in  1 each  control from ID/EX
- ALUOp_E  in  4  ALU operation
- RsE, RtE, RdE  in  RA_W  register numbers
- RFD1_E, RFD2_E  in  WIDTH  register-file operands
- SIMM_E  in  WIDTH  sign-extended immediate
- ForwardAE, ForwardBE  in  2  forwarding select: 00 = RFD, 10 = ALUOutM, 01 = ResultW, 11 = treated as 00
- ResultW  in  WIDTH  writeback-stage result
- STALL_E  out  1  hold request to the hazard unit (freezes PC, IF/ID, ID/EX)
- WriteRegE  out  RA_W  combinational destination, for hazard detection
- RFWEM, DMWEM, MtoRFselM  out  1 each  registered control
- ALUOutM, WriteDataM  out  WIDTH  registered ALU result and store data
- WriteRegM  out  RA_W  registered destination
- OVF_M  out  1  overflow flag; present only with the optional feature

Behaviour:
- Reset (CLR_N = 0, asynchronous): all M outputs are 0, state = IDLE, iteration counter = 0, multiply registers = 0. The reset takes effect immediately, including mid-multiply.
- Operand selection:
  - SrcAE = fwd(RFD1_E, ForwardAE).
  - WriteDataE = fwd(RFD2_E, ForwardBE).
  - SrcBE = ALU_sel_E ? SIMM_E : WriteDataE.
- WriteRegE = RFDSelE ? RdE : RtE.
- ALUOp encoding (all results are WIDTH bits; unused codes give 0):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR
  - 0110 SUB (A−B), 0111 SLT (signed; result is 1 or 0)
  - 1000 SLL (A << B[4:0]), 1001 SRL, 1010 SRA
  - 1011 MUL (low WIDTH bits of A×B, two's complement)
- Single-cycle ops:
  - EX/MEM captures every cycle STALL_E = 0.
  - Latency is 1 cycle from ID/EX to M outputs.
- Multiply FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - If ALUOp_E = 1011: STALL_E = 1 (combinational). Latch multiplicand = SrcAE, multiplier = SrcBE, accumulator = 0, counter = 0. Go to BUSY.
    - Otherwise: STALL_E = 0 and normal capture.
  - BUSY:
    - STALL_E = 1.
    - Each cycle: if multiplier[0] = 1, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
    - After the WIDTH-th iteration (counter = WIDTH−1 at the edge), go to DONE.
  - DONE:
    - STALL_E = 0. ALUOutM captures the accumulator; control and WriteRegM capture the inputs still held in ID/EX. Go to IDLE.
  - A back-to-back MUL in the next instruction restarts from IDLE normally.
  - Total stall is WIDTH+1 cycles; the multiply occupies EX for WIDTH+2 cycles.
- While STALL_E = 1, EX/MEM loads a bubble: RFWEM = 0, DMWEM = 0, MtoRFselM = 0, ALUOutM, WriteDataM and WriteRegM = 0. This keeps MEM/WB draining, so forwarding from older instructions stays valid.
- Operands are frozen at the IDLE latch. Forward/RFD changes during BUSY are ignored.
- Arithmetic wraps modulo 2^WIDTH. No exceptions without the optional feature.

Optional Feature:
- Macro: EX_OVERFLOW_TRAP_EN.
- Defined:
  - Signed overflow on ADD (0010) or SUB (0110) sets OVF_M = 1 for that instruction's EX/MEM slot.
  - It also forces RFWEM = 0 and DMWEM = 0, so the result is not committed. ALUOutM still holds the wrapped sum.
  - OVF_M resets to 0 and is 0 for bubbles and all other ops.
- Undefined: the OVF_M port and its logic are absent, and overflow wraps silently.

Test Plan:
- ADD: CLR_N pulse, then ALUOp_E = 0010, SrcA = 5, SIMM = 7, ALU_sel_E = 1, RFDSelE = 0, RtE = 9, RFWEE = 1 -> next edge ALUOutM = 12, WriteRegM = 9, RFWEM = 1, STALL_E stays 0.
- Forwarding: ForwardAE = 10 with ALUOutM = 0x10 and ForwardBE = 01 with ResultW = 0x3, SUB -> ALUOutM = 0xD and WriteDataM = 0x3 (since ALU_sel_E = 0).
- Multiply: MUL with 0xFFFFFFFD (−3) × 7 -> STALL_E high exactly 33 cycles and bubbles (RFWEM = 0) during the stall. The following edge gives ALUOutM = 0xFFFFFFEB (−21), RFWEM = 1.
- Reset mid-multiply: assert CLR_N = 0 during BUSY cycle 10 -> immediately STALL_E = 0 and all M outputs 0. After release, an ADD 1+1 completes in 1 cycle with result 2.
- Back-to-back MUL 3×4 then MUL 5×6 -> results 12 and 30 in order, each preceded by a 33-cycle stall, no lost or duplicated instruction.
- With EX_OVERFLOW_TRAP_EN: ADD 0x7FFFFFFF + 1 -> OVF_M = 1, RFWEM = 0, ALUOutM = 0x80000000. Without the macro: RFWEM = 1 and no OVF_M port.

Source files
------------

// File: rtl/pipe_ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the MIPS execute stage.
// OVF_M exists only when EX_OVERFLOW_TRAP_EN is defined.
interface pipe_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);
  logic             RFWEE;
  logic             DMWEE;
  logic             MtoRFsel_E;
  logic             RFDSelE;
  logic             ALU_sel_E;
  logic [3:0]       ALUOp_E;
  logic [RA_W-1:0]  RsE;
  logic [RA_W-1:0]  RtE;
  logic [RA_W-1:0]  RdE;
  logic [WIDTH-1:0] RFD1_E;
  logic [WIDTH-1:0] RFD2_E;
  logic [WIDTH-1:0] SIMM_E;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [WIDTH-1:0] ResultW;
  logic             STALL_E;
  logic [RA_W-1:0]  WriteRegE;
  logic             RFWEM;
  logic             DMWEM;
  logic             MtoRFselM;
  logic [WIDTH-1:0] ALUOutM;
  logic [WIDTH-1:0] WriteDataM;
  logic [RA_W-1:0]  WriteRegM;
`ifdef EX_OVERFLOW_TRAP_EN
  logic             OVF_M;
`endif

  modport slave (
    input  RFWEE, DMWEE, MtoRFsel_E, RFDSelE, ALU_sel_E, ALUOp_E,
    input  RsE, RtE, RdE, RFD1_E, RFD2_E, SIMM_E,
    input  ForwardAE, ForwardBE, ResultW,
    output STALL_E, WriteRegE, RFWEM, DMWEM, MtoRFselM,
    output ALUOutM, WriteDataM, WriteRegM
`ifdef EX_OVERFLOW_TRAP_EN
    , output OVF_M
`endif
  );

  modport master (
    output RFWEE, DMWEE, MtoRFsel_E, RFDSelE, ALU_sel_E, ALUOp_E,
    output RsE, RtE, RdE, RFD1_E, RFD2_E, SIMM_E,
    output ForwardAE, ForwardBE, ResultW,
    input  STALL_E, WriteRegE, RFWEM, DMWEM, MtoRFselM,
    input  ALUOutM, WriteDataM, WriteRegM
`ifdef EX_OVERFLOW_TRAP_EN
    , input OVF_M
`endif
  );
endinterface

// File: rtl/pipe_ex_stage.sv
// MIPS execute stage: forwarding, ALU, iterative shift-add multiply, EX/MEM register.
// Optional signed-overflow trap on ADD/SUB is enabled with EX_OVERFLOW_TRAP_EN.
module pipe_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic             CLK,
  input logic             CLR_N,
  pipe_ex_stage_if.slave  ex
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] fwd(
    input logic [WIDTH-1:0] rfd,
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] alu_m,
    input logic [WIDTH-1:0] res_w
  );
    case (sel)
      2'b10:   fwd = alu_m;
      2'b01:   fwd = res_w;
      default: fwd = rfd;
    endcase
  endfunction

  // MUL is not handled here; its result comes from the multiply accumulator
  function automatic logic [WIDTH-1:0] alu(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (op)
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_ADD:  alu = a + b;
      OP_XOR:  alu = a ^ b;
      OP_NOR:  alu = ~(a | b);
      OP_SUB:  alu = a - b;
      OP_SLT:  alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu = a << b[SH_W-1:0];
      OP_SRL:  alu = a >> b[SH_W-1:0];
      OP_SRA:  alu = $unsigned($signed(a) >>> b[SH_W-1:0]);
      default: alu = {WIDTH{1'b0}};
    endcase
  endfunction

`ifdef EX_OVERFLOW_TRAP_EN
  function automatic logic add_sub_ovf(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r
  );
    case (op)
      OP_ADD:  add_sub_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  add_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: add_sub_ovf = 1'b0;
    endcase
  endfunction
`endif

  state_t           state_r, state_next_s;
  logic             stall_s, mul_start_s, mul_step_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] mcand_r, mplier_r, acc_r;

  logic [WIDTH-1:0] src_a_s, src_b_s, write_data_s, alu_res_s;
  logic [RA_W-1:0]  write_reg_s;

  logic             rfwe_r, dmwe_r, mtorf_r;
  logic [WIDTH-1:0] alu_out_r, wdata_r;
  logic [RA_W-1:0]  wreg_r;
  logic             rfwe_n_s, dmwe_n_s, mtorf_n_s;
  logic [WIDTH-1:0] alu_out_n_s, wdata_n_s;
  logic [RA_W-1:0]  wreg_n_s;
`ifdef EX_OVERFLOW_TRAP_EN
  logic             ovf_r, ovf_n_s;
`endif

  // Operand forwarding, source-B mux, destination select and single-cycle ALU
  always_comb begin
    src_a_s      = fwd(ex.RFD1_E, ex.ForwardAE, alu_out_r, ex.ResultW);
    write_data_s = fwd(ex.RFD2_E, ex.ForwardBE, alu_out_r, ex.ResultW);
    src_b_s      = ex.ALU_sel_E ? ex.SIMM_E : write_data_s;
    write_reg_s  = ex.RFDSelE ? ex.RdE : ex.RtE;
    alu_res_s    = alu(ex.ALUOp_E, src_a_s, src_b_s);
  end

  // Multiply FSM state register
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Multiply FSM next-state and stall/iteration controls
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    mul_start_s  = 1'b0;
    mul_step_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ex.ALUOp_E == OP_MUL) begin
          stall_s      = 1'b1;
          mul_start_s  = 1'b1;
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s    = 1'b1;
        mul_step_s = 1'b1;
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Shift-add multiply datapath; operands are frozen at the IDLE latch
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (mul_start_s) begin
      mcand_r  <= src_a_s;
      mplier_r <= src_b_s;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (mul_step_s) begin
      acc_r    <= mplier_r[0] ? (acc_r + mcand_r) : acc_r;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // EX/MEM next value: a bubble while stalled, otherwise the current instruction
  always_comb begin
    rfwe_n_s    = 1'b0;
    dmwe_n_s    = 1'b0;
    mtorf_n_s   = 1'b0;
    alu_out_n_s = {WIDTH{1'b0}};
    wdata_n_s   = {WIDTH{1'b0}};
    wreg_n_s    = {RA_W{1'b0}};
`ifdef EX_OVERFLOW_TRAP_EN
    ovf_n_s     = 1'b0;
`endif
    if (stall_s) begin
      rfwe_n_s = 1'b0;
      dmwe_n_s = 1'b0;
    end else begin
      mtorf_n_s   = ex.MtoRFsel_E;
      alu_out_n_s = (state_r == ST_DONE) ? acc_r : alu_res_s;
      wdata_n_s   = write_data_s;
      wreg_n_s    = write_reg_s;
`ifdef EX_OVERFLOW_TRAP_EN
      ovf_n_s     = (state_r != ST_DONE) &&
                    add_sub_ovf(ex.ALUOp_E, src_a_s, src_b_s, alu_res_s);
      rfwe_n_s    = ex.RFWEE & ~ovf_n_s;
      dmwe_n_s    = ex.DMWEE & ~ovf_n_s;
`else
      rfwe_n_s    = ex.RFWEE;
      dmwe_n_s    = ex.DMWEE;
`endif
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      rfwe_r    <= 1'b0;
      dmwe_r    <= 1'b0;
      mtorf_r   <= 1'b0;
      alu_out_r <= {WIDTH{1'b0}};
      wdata_r   <= {WIDTH{1'b0}};
      wreg_r    <= {RA_W{1'b0}};
`ifdef EX_OVERFLOW_TRAP_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      rfwe_r    <= rfwe_n_s;
      dmwe_r    <= dmwe_n_s;
      mtorf_r   <= mtorf_n_s;
      alu_out_r <= alu_out_n_s;
      wdata_r   <= wdata_n_s;
      wreg_r    <= wreg_n_s;
`ifdef EX_OVERFLOW_TRAP_EN
      ovf_r     <= ovf_n_s;
`endif
    end
  end

  // Stall drops the moment reset asserts, even with a MUL still held in ID/EX
  assign ex.STALL_E    = stall_s & CLR_N;
  assign ex.WriteRegE  = write_reg_s;
  assign ex.RFWEM      = rfwe_r;
  assign ex.DMWEM      = dmwe_r;
  assign ex.MtoRFselM  = mtorf_r;
  assign ex.ALUOutM    = alu_out_r;
  assign ex.WriteDataM = wdata_r;
  assign ex.WriteRegM  = wreg_r;
`ifdef EX_OVERFLOW_TRAP_EN
  assign ex.OVF_M      = ovf_r;
`endif

endmodule
